// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core front end.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns PC and IR, runs the imem req/ack handshake.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// FETCH_IDLE  | no request outstanding, ir not fresh (after reset/timeout)
// FETCH_WAIT  | imem_req high at fetch_pc, waiting for ack or timeout
// FETCH_VALID | ir/pc hold a freshly fetched instruction
module if_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            pc_we,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc,
    output logic            ir_valid,
    output logic            misalign,
    output logic            fetch_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            misalign_q, misalign_d;
    logic            fetch_err_q, fetch_err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      cnt_inc;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_IDLE;
            fetch_pc_q  <= RESET_PC;
            pc_q        <= RESET_PC;
            ir_q        <= NOP_INSN;
            ir_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            misalign_q  <= misalign_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: fetch handshake, wait timer, and the PC commit that may
    // redirect an outstanding request.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        misalign_d  = misalign_q;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + 8'd1;

        unique case (state_q)
            FETCH_IDLE, FETCH_VALID: begin
                if (fetch_en) begin
                    state_d    = FETCH_WAIT;
                    ir_valid_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            FETCH_WAIT: begin
                // A redirect wins over a same-cycle ack: that word belongs
                // to the stale address.
                if (pc_we) begin
                    cnt_d = '0;
                end else if (imem_ack) begin
                    ir_d       = imem_rdata;
                    pc_d       = fetch_pc_q;
                    ir_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = FETCH_VALID;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    fetch_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = FETCH_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (pc_we) begin
            if (pc_src) begin
                fetch_pc_d = {branch_target[XLEN-1:2], 2'b00};
                misalign_d = |branch_target[1:0];
            end else begin
                fetch_pc_d = pc_q + XLEN'(4);
                misalign_d = 1'b0;
            end
        end
    end

    assign imem_req  = (state_q == FETCH_WAIT);
    assign imem_addr = fetch_pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign pc        = pc_q;
    assign ir_valid  = ir_valid_q;
    assign misalign  = misalign_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the multicycle RISC-V core. Sits directly upstream of the control unit.
- Owns the PC and the instruction register (IR), and runs the request/acknowledge handshake with instruction memory.
- Presents the IR, its opcode field and its PC to the control unit and datapath.
- Updates the PC once per instruction, at write-back: sequential (+4) or branch target.

Parameters:
XLEN, 32, width of PC and addresses
RESET_PC, 32'h0000_0000, first fetch address after reset
TIMEOUT, 15, maximum cycles spent in WAIT before a fetch error is flagged (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
fetch_en  in  1  control unit requests the next instruction (FETCH state)
pc_we  in  1  control unit commits the PC update (WRITE_BACK state)
pc_src  in  1  0: PC+4, 1: branch_target (sampled only with pc_we)
branch_target  in  XLEN  branch/jump target from datapath
imem_req  out  1  instruction-memory request
imem_addr  out  XLEN  request address
imem_ack  in  1  memory response valid this cycle
imem_rdata  in  32  instruction word, valid with imem_ack
ir  out  32  instruction register
opcode  out  7  ir[6:0]
pc  out  XLEN  address of the instruction held in ir
ir_valid  out  1  ir holds a freshly fetched instruction
misalign  out  1  last committed branch target had bits [1:0] != 0
fetch_err  out  1  sticky: WAIT exceeded TIMEOUT

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; fetch_pc=RESET_PC; pc=RESET_PC.
  - ir=32'h0000_0013 (NOP), ir_valid=0, misalign=0, fetch_err=0, wait counter=0.
  - imem_req=0, imem_addr=RESET_PC.
- FSM states: IDLE, WAIT, VALID.
  - imem_req=1 exactly when state==WAIT.
  - imem_addr=fetch_pc in all states and is stable throughout WAIT.
- IDLE or VALID, fetch_en=1 -> WAIT next cycle.
  - ir_valid clears on entering WAIT.
  - ir and pc keep their old values.
- WAIT, imem_ack=1 and pc_we=0:
  - ir<=imem_rdata, pc<=fetch_pc, ir_valid<=1, counter<=0, -> VALID.
- Latency: fetch_en at cycle n -> imem_req at n+1 -> ir_valid at n+2 for a zero-wait memory. Each wait cycle adds one cycle.
- fetch_en while in WAIT is ignored; no second request is queued.
- pc_we=1 in any state updates fetch_pc:
  - pc_src=0: fetch_pc <= pc + 4 (mod 2^XLEN; wraps from 32'hFFFF_FFFC to 0).
  - pc_src=1: fetch_pc <= {branch_target[XLEN-1:2], 2'b00}, and misalign <= |branch_target[1:0].
  - pc_src=0 clears misalign.
- pc_we in WAIT is a redirect:
  - An imem_ack in the same cycle is discarded (ir and pc unchanged).
  - State stays WAIT and the counter restarts at 0.
  - From the next cycle imem_addr shows the new fetch_pc.
- pc_we with fetch_en in the same cycle (IDLE/VALID): both take effect. The request issued next cycle uses the updated fetch_pc.
- Timeout: the counter increments each WAIT cycle without an ack. When it reaches TIMEOUT:
  - fetch_err <= 1, -> IDLE (request dropped), counter <= 0.
  - fetch_err is cleared only by reset.
- An ack while not in WAIT is ignored.
- Reset asserted mid-WAIT: imem_req drops immediately (async). Any ack arriving during reset is ignored.
- The fetch_pc register is internal; pc reflects only committed fetches.

Decomposition:
- Shared package riscv_pkg:
  - fetch state enum (IDLE/WAIT/VALID)
  - NOP_INSN = 32'h0000_0013
  - OPCODE_LSB/OPCODE_MSB field constants
  - XLEN default
- Single module; no sub-module warranted. PC and IR logic are small enough to stay inline.

Test Plan:
- Reset release, fetch_en pulse, memory acks in the same cycle as the request with 32'h00500093 -> imem_addr=0 at n+1; ir=32'h00500093, opcode=7'h13, pc=0, ir_valid=1 at n+2.
- Memory inserts 3 wait cycles -> imem_req high for 4 cycles, imem_addr constant at fetch_pc; ir_valid rises on the cycle after the ack.
- pc_we=1, pc_src=0 with pc=32'h10; then fetch_en -> imem_addr=32'h14. Repeat with pc=32'hFFFF_FFFC -> imem_addr=0 (wrap).
- pc_we=1, pc_src=1, branch_target=32'h0000_0102 -> misalign=1, next imem_addr=32'h0000_0100.
- In WAIT at address 32'h20, assert pc_we (pc_src=1, target 32'h40) in the same cycle as imem_ack -> ir unchanged, ir_valid=0, next imem_addr=32'h40; a later ack loads pc=32'h40.
- Never ack, TIMEOUT=15 -> after 15 WAIT cycles fetch_err=1, imem_req=0, state IDLE. Separately, rst_n low mid-WAIT -> imem_req=0 immediately and all outputs at reset values.
